// File: rtl/cc_reqrsp_d32_arbiter.sv
// Round-robin arbiter sharing one 32b reqrsp port among NUM_REQ requesters.
// Responses return in order; an ID FIFO remembers which requester owns each
// outstanding request so the p channel can be routed back without tags.
//
// Handshake rule (both q and p channels): a transfer happens in any cycle where
// valid && ready are both high; valid must not depend on ready, and once valid
// is raised the source holds valid and payload stable until the transfer.

package CC_ITF_PKG;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic [3:0]  strb;
  } reqrsp_d32_q_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } reqrsp_d32_p_t;

  typedef struct packed {
    reqrsp_d32_q_t q;
    logic          q_valid;
    logic          p_ready;
  } reqrsp_d32_req_t;

  typedef struct packed {
    logic          q_ready;
    reqrsp_d32_p_t p;
    logic          p_valid;
  } reqrsp_d32_resps_t;
endpackage

module cc_reqrsp_d32_arbiter
  import CC_ITF_PKG::*;
#(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  reqrsp_d32_req_t                      slv_req_i [NUM_REQ],
  output reqrsp_d32_resps_t                    slv_rsp_o [NUM_REQ],
  output reqrsp_d32_req_t                      mst_req_o,
  input  reqrsp_d32_resps_t                    mst_rsp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [IW-1:0] rr_q;
  logic          lock_q;
  logic [IW-1:0] locked_idx_q;

  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic [IW-1:0] grant;
  logic          grant_valid;
  logic          full;
  logic          empty;
  logic          q_valid_out;
  logic          q_hs;
  logic          p_hs;
  logic [IW-1:0] head;

  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];
  assign outstanding_o = count_q;

  // Pick the requester: a locked grant wins, otherwise scan from rr_q upward.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (lock_q) begin
      grant       = locked_idx_q;
      grant_valid = slv_req_i[locked_idx_q].q_valid;
    end else begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (!grant_valid && slv_req_i[(int'(rr_q) + k) % int'(NUM_REQ)].q_valid) begin
          grant       = IW'((int'(rr_q) + k) % int'(NUM_REQ));
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Outputs are forced quiet while reset is asserted, whatever the inputs do.
  assign q_valid_out = grant_valid && !full && !rst_i;
  assign q_hs        = q_valid_out && mst_rsp_i.q_ready;
  assign p_hs        = !rst_i && !empty && mst_rsp_i.p_valid && slv_req_i[head].p_ready;

  // Downstream request: muxed payload of the granted requester, zero otherwise.
  always_comb begin
    mst_req_o         = '0;
    mst_req_o.q_valid = q_valid_out;
    mst_req_o.q       = q_valid_out ? slv_req_i[grant].q : '0;
    mst_req_o.p_ready = !rst_i && !empty && slv_req_i[head].p_ready;
  end

  // Per-requester q_ready (granted port only) and p routing to the FIFO head.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      slv_rsp_o[i]         = '0;
      slv_rsp_o[i].q_ready = q_valid_out && (grant == IW'(i)) && mst_rsp_i.q_ready;
      if (!rst_i && !empty && (head == IW'(i))) begin
        slv_rsp_o[i].p       = mst_rsp_i.p;
        slv_rsp_o[i].p_valid = mst_rsp_i.p_valid;
      end
    end
  end

  // Round-robin pointer and grant lock; the lock holds a stalled grant steady.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q         <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
    end else if (q_hs) begin
      rr_q   <= IW'((int'(grant) + 1) % int'(NUM_REQ));
      lock_q <= 1'b0;
    end else if (q_valid_out) begin
      lock_q       <= 1'b1;
      locked_idx_q <= grant;
    end
  end

  // ID FIFO storage: owner index written on every accepted request.
  always_ff @(posedge clk_i) begin
    if (q_hs) begin
      fifo_q[wr_ptr_q] <= grant;
    end
  end

  // ID FIFO pointers and occupancy; pointers wrap at MAX_OUTSTANDING.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (q_hs) begin
        wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (p_hs) begin
        rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({q_hs, p_hs})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Protocol checks: no FIFO overflow/underflow, stalled request held stable.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) !(q_hs && full));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(mst_rsp_i.p_valid && empty));
  a_q_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (mst_req_o.q_valid && !mst_rsp_i.q_ready) |=> (mst_req_o.q_valid && $stable(mst_req_o.q)));

endmodule
